cnu_minsum_param: RTL and testbench
===================================

Name: cnu_minsum_param

Overview:
Parametrised check node unit for the LDPC decoder. It is the successor to the fixed six-input CNU and replaces the fixed-degree datapath with an offset min-sum datapath. It adds support for irregular codes through a runtime per-row edge mask and a runtime offset. It has a two-stage pipeline with valid/ready flow control and synchronous reset. It sits between the PE blocks, which supply per-edge messages, and the PE write-back path, which consumes the check-to-variable messages.

Parameters:
DEG, 6, maximum check-node degree (number of edges); legal range 2..32
MAG_W, 4, magnitude width of each message
IDX_W, clog2(DEG), derived localparam; width of the min1 index

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset; overrides en
en  input  1  global enable; en=0 freezes every register, including valid bits
X  input  DEG*(MAG_W+2)  edge e occupies slice [e*(MAG_W+2) +: MAG_W+2]; within each slice, MSB is the hard decision, next bit is the sign (1=negative), low MAG_W bits are the magnitude
edge_mask  input  DEG  1 = edge active in this row
offset  input  MAG_W  min-sum offset, sampled with X
in_valid  input  1  X/edge_mask/offset valid
in_ready  output  1  block accepts the vector this cycle
Y  output  DEG*(MAG_W+1)  edge e occupies slice [e*(MAG_W+1) +: MAG_W+1]; within each slice, MSB is the sign, low MAG_W bits are the magnitude
p_bit  output  1  parity (XOR) of the active hard decisions
out_valid  output  1  Y/p_bit valid
out_ready  input  1  downstream accepts Y

Behaviour:
- Pipeline advance:
  - adv = en && (!out_valid || out_ready).
  - in_ready = adv (combinational).
  - A transfer occurs when in_valid && in_ready.
  - When adv=1: stage1 <= {input, v1 <= in_valid}; stage2 <= {f(stage1), v2 <= v1}.
  - When adv=0: nothing changes.
- Latency: an accepted vector appears on Y with out_valid=1 exactly 2 cycles after acceptance when there is no stall. Throughput is 1 vector per cycle. Order is preserved, with no loss and no duplication.
- Masked edges (edge_mask[e]=0):
  - magnitude is treated as all-ones;
  - sign is treated as 0;
  - hard decision is treated as 0;
  - output slice is forced to 0.
- Stage 1 (registered), computed over the active edges:
  - min1 = smallest magnitude; idx = lowest edge index holding min1;
  - min2 = smallest magnitude excluding edge idx (ties give min2 = min1);
  - sxor = XOR of the signs;
  - par = XOR of the hard decisions;
  - the per-edge signs, edge_mask and offset are also registered.
- Stage 2 (registered outputs), per active edge e:
  - m = (e==idx) ? min2 : min1;
  - magnitude = saturating (m - offset): result is 0 when offset ≥ m;
  - sign = sxor ^ sign_e.
- Degree corner cases:
  - Exactly 1 active edge: min2 = all-ones, so that edge's output magnitude = all-ones - offset.
  - 0 active edges: all Y = 0 and p_bit = 0, but out_valid still follows v1.
- Holding: Y, p_bit and out_valid hold stable while out_valid && !out_ready, and while en=0.
- Bubbles: when v1=0, stage 2 still loads but out_valid=0. Y content while out_valid=0 is don't-care, except after reset.
- Reset (rst=1 at a clock edge):
  - v1, v2, Y, p_bit and all stage-1 registers go to 0 on that edge;
  - in_ready = 0 while rst=1;
  - in-flight vectors are discarded;
  - in_valid is ignored;
  - the first acceptance is possible in the cycle after rst deasserts (given en=1).
- Widths:
  - all comparisons are unsigned on MAG_W bits;
  - no arithmetic overflow is possible;
  - the subtraction uses a MAG_W+1 bit borrow for saturation.

Test Plan:
All scenarios use DEG=6 and MAG_W=4.
- Basic accept and latency:
  - Stimulus: mags {5,2,7,9,3,12}, signs {0,0,1,0,0,0}, hd {1,0,1,1,0,0}, mask 6'h3F, offset 0, accepted at cycle T.
  - Required response at T+2: out_valid=1; edge1 magnitude 3; all other edges magnitude 2; edge2 sign 0, other edges sign 1; p_bit=1.
- Offset and saturation, same data:
  - offset=2: edge1 magnitude 1, others 0.
  - offset=15: all magnitudes 0, signs unchanged.
- Irregular row:
  - Stimulus: mask 6'b001111, mags {5,2,7,9,1,0}, hd {0,0,0,0,1,1}.
  - Required response: edge1=5; edges 0,2,3 = 2; edges 4,5 = 0; p_bit=0.
- Tie and single edge:
  - Stimulus 1: mags {4,4,8,8,8,8} (all active). Required: all magnitudes 4.
  - Stimulus 2: mask 6'b000001, offset 3. Required: edge0 magnitude 12; other edges 0.
- Back-pressure:
  - Stimulus: stream 4 distinct vectors back-to-back; hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready=0 during the stall; Y stable; all 4 results delivered in order with no gaps once out_ready=1.
- Reset and enable:
  - Stimulus: assert rst for 1 cycle with 2 vectors in flight. Required: out_valid=0 and Y=0 the next cycle; the discarded vectors never appear.
  - Stimulus: drive en=0 for 2 cycles mid-stream. Required: all outputs frozen; the stream resumes intact.

Source files
------------

// File: rtl/cnu_minsum_param.sv
// Offset min-sum check node unit with a runtime edge mask. Stage 1 registers
// min1/min2/idx plus sign and parity reductions; stage 2 registers the per-edge messages.
module cnu_minsum_param #(
  parameter int DEG   = 6,
  parameter int MAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DEG*(MAG_W+2)-1:0] X,
  input  logic [DEG-1:0]           edge_mask,
  input  logic [MAG_W-1:0]         offset,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DEG*(MAG_W+1)-1:0] Y,
  output logic                     p_bit,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int IDX_W = $clog2(DEG);
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  logic adv;

  // Masked edges look like the largest magnitude, positive, hard decision 0
  logic [MAG_W-1:0] mag_eff [DEG];
  logic [DEG-1:0]   sign_eff;
  logic [DEG-1:0]   hd_eff;

  logic [MAG_W-1:0] min1_next;
  logic [MAG_W-1:0] min2_next;
  logic [IDX_W-1:0] idx_next;

  logic             v1_reg;
  logic [MAG_W-1:0] min1_reg;
  logic [MAG_W-1:0] min2_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             sxor_reg;
  logic             par_reg;
  logic [DEG-1:0]   sign_reg;
  logic [DEG-1:0]   mask_reg;
  logic [MAG_W-1:0] offset_reg;

  logic [DEG*(MAG_W+1)-1:0] y_next;
  logic [DEG*(MAG_W+1)-1:0] y_reg;
  logic                     p_bit_reg;
  logic                     v2_reg;

  assign adv      = en && !rst && (!v2_reg || out_ready);
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < DEG; gi++) begin : g_in
      assign mag_eff[gi]  = edge_mask[gi] ? X[gi*(MAG_W+2) +: MAG_W] : MAG_MAX;
      assign sign_eff[gi] = edge_mask[gi] & X[gi*(MAG_W+2) + MAG_W];
      assign hd_eff[gi]   = edge_mask[gi] & X[gi*(MAG_W+2) + MAG_W + 1];
    end
  endgenerate

  // Strict less-than keeps the lowest index on ties; min2 skips only that index
  always_comb begin
    min1_next = MAG_MAX;
    idx_next  = '0;
    for (int e = 0; e < DEG; e++) begin
      if (mag_eff[e] < min1_next) begin
        min1_next = mag_eff[e];
        idx_next  = IDX_W'(e);
      end
    end
    min2_next = MAG_MAX;
    for (int e = 0; e < DEG; e++) begin
      if ((IDX_W'(e) != idx_next) && (mag_eff[e] < min2_next)) begin
        min2_next = mag_eff[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg     <= 1'b0;
      min1_reg   <= '0;
      min2_reg   <= '0;
      idx_reg    <= '0;
      sxor_reg   <= 1'b0;
      par_reg    <= 1'b0;
      sign_reg   <= '0;
      mask_reg   <= '0;
      offset_reg <= '0;
    end else if (adv) begin
      v1_reg     <= in_valid;
      min1_reg   <= min1_next;
      min2_reg   <= min2_next;
      idx_reg    <= idx_next;
      sxor_reg   <= ^sign_eff;
      par_reg    <= ^hd_eff;
      sign_reg   <= sign_eff;
      mask_reg   <= edge_mask;
      offset_reg <= offset;
    end
  end

  generate
    for (gi = 0; gi < DEG; gi++) begin : g_out
      logic [MAG_W-1:0] m_sel;
      logic [MAG_W:0]   diff;
      logic [MAG_W-1:0] mag_sat;
      assign m_sel   = (idx_reg == IDX_W'(gi)) ? min2_reg : min1_reg;
      // Borrow out of the extra bit means offset >= m, so clamp to zero
      assign diff    = {1'b0, m_sel} - {1'b0, offset_reg};
      assign mag_sat = diff[MAG_W] ? {MAG_W{1'b0}} : diff[MAG_W-1:0];
      assign y_next[gi*(MAG_W+1) +: MAG_W+1] =
        mask_reg[gi] ? {sxor_reg ^ sign_reg[gi], mag_sat} : {(MAG_W+1){1'b0}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg    <= 1'b0;
      y_reg     <= '0;
      p_bit_reg <= 1'b0;
    end else if (adv) begin
      v2_reg    <= v1_reg;
      y_reg     <= y_next;
      p_bit_reg <= par_reg;
    end
  end

  assign Y         = y_reg;
  assign p_bit     = p_bit_reg;
  assign out_valid = v2_reg;

endmodule

// File: tb/tb_cnu_minsum_param.sv
// Directed bench for cnu_minsum_param (DEG=6, MAG_W=4) with hand-computed expected messages.
module tb_cnu_minsum_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [35:0] X;
  logic [5:0]  edge_mask;
  logic [3:0]  offset;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] Y;
  logic        p_bit;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic [35:0] xa, xb, xc;
  logic [29:0] ya0, ya2, ya15, yb, yc, yd;

  always #5 clk = ~clk;

  cnu_minsum_param #(.DEG(6), .MAG_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .X(X), .edge_mask(edge_mask), .offset(offset),
    .in_valid(in_valid), .in_ready(in_ready), .Y(Y), .p_bit(p_bit),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Each input edge is {hd, sign, mag}; each output edge is {sign, mag}
  function automatic logic [35:0] mkx(input logic [5:0] e0, e1, e2, e3, e4, e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [29:0] mky(input logic [4:0] e0, e1, e2, e3, e4, e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [35:0] x, input logic [5:0] m, input logic [3:0] o, input logic v);
    X = x;
    edge_mask = m;
    offset = o;
    in_valid = v;
  endtask

  task automatic run_vec(input logic [35:0] x, input logic [5:0] m, input logic [3:0] o, output logic early);
    drive(x, m, o, 1'b1);
    step();
    in_valid = 1'b0;
    early = out_valid;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    drive(xa, 6'h3F, 4'd0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || Y !== 30'd0 || p_bit !== 1'b0) begin
      errors++; $display("FAIL reset_state: out_valid=%b Y=%h p_bit=%b want 0/0/0", out_valid, Y, p_bit);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic early;
    run_vec(xa, 6'h3F, 4'd0, early);
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid=%b want 0", early); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++;
    if (Y !== ya0) begin errors++; $display("FAIL basic_y: got %h want %h", Y, ya0); end
    checks++;
    if (p_bit !== 1'b1) begin errors++; $display("FAIL basic_parity: got %b want 1", p_bit); end
    $display("test_basic: Y=%h p_bit=%b", Y, p_bit);
  endtask

  task automatic test_offset();
    logic early;
    run_vec(xa, 6'h3F, 4'd2, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== ya2 || p_bit !== 1'b1) begin
      errors++; $display("FAIL offset2: valid=%b Y=%h p=%b want 1/%h/1", out_valid, Y, p_bit, ya2);
    end
    $display("test_offset: offset=2 Y=%h", Y);
    run_vec(xa, 6'h3F, 4'd15, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== ya15 || p_bit !== 1'b1) begin
      errors++; $display("FAIL offset15: valid=%b Y=%h p=%b want 1/%h/1", out_valid, Y, p_bit, ya15);
    end
    $display("test_offset: offset=15 Y=%h", Y);
  endtask

  task automatic test_irregular();
    logic early;
    run_vec(xb, 6'b001111, 4'd0, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== yb) begin
      errors++; $display("FAIL irregular_y: valid=%b Y=%h want 1/%h", out_valid, Y, yb);
    end
    checks++;
    if (p_bit !== 1'b0) begin errors++; $display("FAIL irregular_parity: got %b want 0", p_bit); end
    $display("test_irregular: Y=%h p_bit=%b", Y, p_bit);
  endtask

  task automatic test_tie_single();
    logic early;
    run_vec(xc, 6'h3F, 4'd0, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== yc) begin
      errors++; $display("FAIL tie_y: valid=%b Y=%h want 1/%h", out_valid, Y, yc);
    end
    $display("test_tie: Y=%h", Y);
    run_vec(xc, 6'b000001, 4'd3, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== yd) begin
      errors++; $display("FAIL single_edge_y: valid=%b Y=%h want 1/%h", out_valid, Y, yd);
    end
    $display("test_single: Y=%h", Y);
    run_vec(xa, 6'b000000, 4'd0, early);
    checks++;
    if (out_valid !== 1'b1 || Y !== 30'd0 || p_bit !== 1'b0) begin
      errors++; $display("FAIL zero_edges: valid=%b Y=%h p=%b want 1/0/0", out_valid, Y, p_bit);
    end
    $display("test_zero_edges: Y=%h p_bit=%b", Y, p_bit);
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [35:0] vx [4];
    logic [5:0]  vm [4];
    logic [3:0]  vo [4];
    logic [29:0] vy [4];
    logic        vp [4];
    int k = 0;
    int r = 0;
    int stall = 0;
    logic acc;
    logic [29:0] hold_y;
    logic hold_p;
    vx = '{xa, xb, xc, xa};
    vm = '{6'h3F, 6'h0F, 6'h3F, 6'h3F};
    vo = '{4'd0, 4'd0, 4'd0, 4'd2};
    vy = '{ya0, yb, yc, ya2};
    vp = '{1'b1, 1'b0, 1'b0, 1'b1};
    hold_y = '0;
    hold_p = 1'b0;
    for (int cyc = 0; cyc < 40 && r < 4; cyc++) begin
      drive(vx[k < 4 ? k : 0], vm[k < 4 ? k : 0], vo[k < 4 ? k : 0], k < 4);
      out_ready = (stall >= 3);
      @(negedge clk);
      if (out_ready && r > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_gap: out_valid=%b want 1 at result %0d", out_valid, r); end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        if (stall > 0) begin
          checks++;
          if (Y !== hold_y || p_bit !== hold_p) begin
            errors++; $display("FAIL bp_hold: Y=%h p=%b want %h/%b", Y, p_bit, hold_y, hold_p);
          end
        end
        hold_y = Y;
        hold_p = p_bit;
        stall++;
      end else if (out_valid) begin
        checks++;
        if (Y !== vy[r] || p_bit !== vp[r]) begin
          errors++; $display("FAIL bp_result%0d: Y=%h p=%b want %h/%b", r, Y, p_bit, vy[r], vp[r]);
        end
        $display("test_back_to_back: result %0d Y=%h p_bit=%b", r, Y, p_bit);
        r++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (r != 4) begin errors++; $display("FAIL bp_count: got %0d results want 4", r); end
    step();
    step();
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1; en = 1'b1;
    drive(xa, 6'h3F, 4'd0, 1'b1);
    step();
    drive(xc, 6'h3F, 4'd0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_inflight_pre: out_valid=%b want 1", out_valid); end
    rst = 1'b1;
    drive(xb, 6'h0F, 4'd0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_inflight_ready: got %b want 0", in_ready); end
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || Y !== 30'd0 || p_bit !== 1'b0) begin
      errors++; $display("FAIL rst_inflight_clear: valid=%b Y=%h p=%b want 0/0/0", out_valid, Y, p_bit);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_ghost: out_valid=%b want 0 cycle %0d", out_valid, i); end
    end
    $display("test_reset_inflight: done");
  endtask

  task automatic test_enable();
    logic [35:0] vx [4];
    logic [5:0]  vm [4];
    logic [3:0]  vo [4];
    logic [29:0] vy [4];
    logic        vp [4];
    int k = 0;
    int r = 0;
    logic acc;
    logic frozen = 1'b0;
    logic [29:0] hold_y;
    logic hold_v;
    logic hold_p;
    vx = '{xc, xa, xb, xa};
    vm = '{6'b000001, 6'h3F, 6'h0F, 6'h3F};
    vo = '{4'd3, 4'd15, 4'd0, 4'd0};
    vy = '{yd, ya15, yb, ya0};
    vp = '{1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && r < 4; cyc++) begin
      drive(vx[k < 4 ? k : 0], vm[k < 4 ? k : 0], vo[k < 4 ? k : 0], k < 4);
      en = !(cyc == 3 || cyc == 4);
      @(negedge clk);
      if (frozen) begin
        checks++;
        if (Y !== hold_y || out_valid !== hold_v || p_bit !== hold_p) begin
          errors++; $display("FAIL en_frozen: Y=%h v=%b p=%b want %h/%b/%b", Y, out_valid, p_bit, hold_y, hold_v, hold_p);
        end
      end
      if (!en) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready: got %b want 0", in_ready); end
      end
      if (out_valid && en) begin
        checks++;
        if (Y !== vy[r] || p_bit !== vp[r]) begin
          errors++; $display("FAIL en_result%0d: Y=%h p=%b want %h/%b", r, Y, p_bit, vy[r], vp[r]);
        end
        $display("test_enable: result %0d Y=%h p_bit=%b", r, Y, p_bit);
        r++;
      end
      hold_y = Y;
      hold_v = out_valid;
      hold_p = p_bit;
      frozen = !en;
      acc = in_valid && in_ready;
      step();
      if (acc) k++;
    end
    en = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (r != 4) begin errors++; $display("FAIL en_count: got %0d results want 4", r); end
  endtask

  initial begin
    xa   = mkx({2'b10, 4'd5}, {2'b00, 4'd2}, {2'b11, 4'd7}, {2'b10, 4'd9}, {2'b00, 4'd3}, {2'b00, 4'd12});
    ya0  = mky({1'b1, 4'd2}, {1'b1, 4'd3}, {1'b0, 4'd2}, {1'b1, 4'd2}, {1'b1, 4'd2}, {1'b1, 4'd2});
    ya2  = mky({1'b1, 4'd0}, {1'b1, 4'd1}, {1'b0, 4'd0}, {1'b1, 4'd0}, {1'b1, 4'd0}, {1'b1, 4'd0});
    ya15 = mky({1'b1, 4'd0}, {1'b1, 4'd0}, {1'b0, 4'd0}, {1'b1, 4'd0}, {1'b1, 4'd0}, {1'b1, 4'd0});
    xb   = mkx({2'b00, 4'd5}, {2'b00, 4'd2}, {2'b00, 4'd7}, {2'b00, 4'd9}, {2'b10, 4'd1}, {2'b10, 4'd0});
    yb   = mky({1'b0, 4'd2}, {1'b0, 4'd5}, {1'b0, 4'd2}, {1'b0, 4'd2}, 5'd0, 5'd0);
    xc   = mkx({2'b00, 4'd4}, {2'b00, 4'd4}, {2'b00, 4'd8}, {2'b00, 4'd8}, {2'b00, 4'd8}, {2'b00, 4'd8});
    yc   = mky({1'b0, 4'd4}, {1'b0, 4'd4}, {1'b0, 4'd4}, {1'b0, 4'd4}, {1'b0, 4'd4}, {1'b0, 4'd4});
    yd   = mky({1'b0, 4'd12}, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    drive(36'd0, 6'd0, 4'd0, 1'b0);

    test_reset();
    test_basic();
    test_offset();
    test_irregular();
    test_tie_single();
    test_back_to_back();
    test_reset_inflight();
    test_enable();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
